// File: rtl/vga_scan_ctrl_if.sv
// vga_scan_ctrl_if: bundles the colour-stage address/colour loop and the DAC/sync outputs
// of the VGA scan controller.
//   addr        scan -> colour stage, {1'b0, x[9:0], y[8:0]} while visible, else 0
//   rgb_r/g/b   colour stage -> scan, combinational function of addr
//   vga_r/g/b   registered pixel colour to the DAC
//   vga_hs/vs   registered syncs, active-low
//   frame_tick  one-clk pulse at the start of vertical blanking
interface vga_scan_ctrl_if;
    logic [19:0] addr;
    logic [2:0]  rgb_r;
    logic [2:0]  rgb_g;
    logic [2:0]  rgb_b;
    logic [2:0]  vga_r;
    logic [2:0]  vga_g;
    logic [2:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        frame_tick;

    // Scan controller side.
    modport master (
        output addr,
        input  rgb_r, rgb_g, rgb_b,
        output vga_r, vga_g, vga_b,
        output vga_hs, vga_vs,
        output frame_tick
    );

    // Colour stage / display side.
    modport slave (
        input  addr,
        output rgb_r, rgb_g, rgb_b,
        input  vga_r, vga_g, vga_b,
        input  vga_hs, vga_vs,
        input  frame_tick
    );
endinterface

// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: VGA raster scan generator. Runs a 25 MHz pixel enable off the 50 MHz clock,
// scans h/v counters over the full frame, presents the visible pixel address to an external
// combinational colour stage and registers the returned colour plus syncs one pixel later.
// Ports:
//   clk  system clock (only clock)
//   rst  synchronous, active-high reset
//   vga  vga_scan_ctrl_if.master: addr out, rgb_* in, vga_* / vga_hs / vga_vs / frame_tick out
module vga_scan_ctrl #(
    parameter int unsigned H_VIS  = 640,
    parameter int unsigned H_FP   = 16,
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned V_VIS  = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33
) (
    input logic        clk,
    input logic        rst,
    vga_scan_ctrl_if.master vga
);

    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    // All counter compares are 10-bit unsigned.
    localparam logic [9:0] HLast    = 10'(H_TOTAL - 1);
    localparam logic [9:0] VLast    = 10'(V_TOTAL - 1);
    localparam logic [9:0] HVisEnd  = 10'(H_VIS);
    localparam logic [9:0] VVisEnd  = 10'(V_VIS);
    localparam logic [9:0] VVisLast = 10'(V_VIS - 1);
    localparam logic [9:0] HSyncOn  = 10'(H_VIS + H_FP);
    localparam logic [9:0] HSyncOff = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VSyncOn  = 10'(V_VIS + V_FP);
    localparam logic [9:0] VSyncOff = 10'(V_VIS + V_FP + V_SYNC);

    logic       pix_en_q;
    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic [2:0] r_q, r_d;
    logic [2:0] g_q, g_d;
    logic [2:0] b_q, b_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       frame_tick_q, frame_tick_d;

    logic h_wrap;
    logic v_wrap;
    logic visible;

    always_comb begin
        h_wrap  = (h_cnt_q == HLast);
        v_wrap  = (v_cnt_q == VLast);
        visible = (h_cnt_q < HVisEnd) && (v_cnt_q < VVisEnd);

        h_cnt_d      = h_cnt_q;
        v_cnt_d      = v_cnt_q;
        r_d          = r_q;
        g_d          = g_q;
        b_d          = b_q;
        hs_d         = hs_q;
        vs_d         = vs_q;
        frame_tick_d = 1'b0;

        if (pix_en_q) begin
            // h and v wrap together at the last pixel of the frame in a single tick.
            h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
            if (h_wrap) begin
                v_cnt_d = v_wrap ? 10'd0 : v_cnt_q + 10'd1;
            end

            // Outputs capture the pre-tick scan position, so they trail addr by one pixel.
            r_d  = visible ? vga.rgb_r : 3'b000;
            g_d  = visible ? vga.rgb_g : 3'b000;
            b_d  = visible ? vga.rgb_b : 3'b000;
            hs_d = !((h_cnt_q >= HSyncOn) && (h_cnt_q < HSyncOff));
            vs_d = !((v_cnt_q >= VSyncOn) && (v_cnt_q < VSyncOff));

            // Fires on the tick that moves the scan onto (0, V_VIS).
            frame_tick_d = h_wrap && (v_cnt_q == VVisLast);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_en_q     <= 1'b0;
            h_cnt_q      <= 10'd0;
            v_cnt_q      <= 10'd0;
            r_q          <= 3'b000;
            g_q          <= 3'b000;
            b_q          <= 3'b000;
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            pix_en_q     <= ~pix_en_q;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            r_q          <= r_d;
            g_q          <= g_d;
            b_q          <= b_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    always_comb begin
        vga.addr       = visible ? {1'b0, h_cnt_q, v_cnt_q[8:0]} : 20'h0;
        vga.vga_r      = r_q;
        vga.vga_g      = g_q;
        vga.vga_b      = b_q;
        vga.vga_hs     = hs_q;
        vga.vga_vs     = vs_q;
        vga.frame_tick = frame_tick_q;
    end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb_vga_scan_ctrl: scoreboard bench for vga_scan_ctrl on a reduced raster
// (24 x 17 total, 16 x 10 visible). Stimulus pushes timed expectations; a negedge monitor
// pops and compares them and accumulates per-frame counts over a window.
module tb_vga_scan_ctrl;

    localparam int unsigned HV = 16, HF = 2, HS = 4, HB = 2;
    localparam int unsigned VV = 10, VF = 2, VS = 2, VB = 3;
    localparam int unsigned HT = HV + HF + HS + HB;   // 24
    localparam int unsigned VT = VV + VF + VS + VB;   // 17
    localparam int unsigned FP = HT * VT;             // 408 pixels per frame

    localparam int SelAddr  = 0;
    localparam int SelHs    = 1;
    localparam int SelVs    = 2;
    localparam int SelFt    = 3;
    localparam int SelRgb   = 4;
    localparam int SelHsCnt = 5;
    localparam int SelVsCnt = 6;
    localparam int SelR7Cnt = 7;
    localparam int SelNzCnt = 8;
    localparam int SelFtCnt = 9;

    typedef struct {
        string       name;
        int unsigned at;
        int          sel;
        logic [19:0] exp;
    } chk_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pat_mode = 1'b0;
    int unsigned cyc = 0;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    int unsigned win_lo = 32'hFFFF_FFFF;
    int unsigned win_hi = 0;
    int unsigned hs_lo_n = 0, vs_lo_n = 0, r7_n = 0, nz_n = 0, ft_n = 0;

    chk_t sb[$];

    vga_scan_ctrl_if vga ();

    vga_scan_ctrl #(
        .H_VIS (HV), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_VIS (VV), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .vga (vga)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Combinational colour stage: constant red, or a pattern derived from addr.
    always_comb begin
        if (!pat_mode) begin
            vga.rgb_r = 3'b111;
            vga.rgb_g = 3'b000;
            vga.rgb_b = 3'b000;
        end else begin
            vga.rgb_r = vga.addr[11:9];
            vga.rgb_g = vga.addr[2:0];
            vga.rgb_b = {vga.addr[9], vga.addr[0], vga.addr[12]};
        end
    end

    function automatic void push(string n, int unsigned at, int sel, logic [19:0] e);
        chk_t c;
        int i;
        c.name = n;
        c.at   = at;
        c.sel  = sel;
        c.exp  = e;
        i = sb.size();
        while (i > 0 && sb[i-1].at > at) i--;
        sb.insert(i, c);
    endfunction

    function automatic logic [19:0] observe(int sel);
        case (sel)
            SelAddr:  return vga.addr;
            SelHs:    return {19'd0, vga.vga_hs};
            SelVs:    return {19'd0, vga.vga_vs};
            SelFt:    return {19'd0, vga.frame_tick};
            SelRgb:   return {11'd0, vga.vga_r, vga.vga_g, vga.vga_b};
            SelHsCnt: return 20'(hs_lo_n);
            SelVsCnt: return 20'(vs_lo_n);
            SelR7Cnt: return 20'(r7_n);
            SelNzCnt: return 20'(nz_n);
            SelFtCnt: return 20'(ft_n);
            default:  return 20'hXXXXX;
        endcase
    endfunction

    // Monitor: window counts first, then any expectations due this cycle.
    initial begin : monitor
        chk_t e;
        logic [19:0] act;
        forever begin
            @(negedge clk);
            if (cyc >= win_lo && cyc <= win_hi) begin
                if (vga.vga_hs === 1'b0) hs_lo_n++;
                if (vga.vga_vs === 1'b0) vs_lo_n++;
                if (vga.vga_r === 3'b111) r7_n++;
                if ({vga.vga_r, vga.vga_g, vga.vga_b} !== 9'd0) nz_n++;
                if (vga.frame_tick === 1'b1) ft_n++;
            end
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                n_tests++;
                if (e.at != cyc) begin
                    n_fail++;
                    $display("FAIL %s: due at cycle %0d, not sampled (now %0d)", e.name, e.at, cyc);
                end else begin
                    act = observe(e.sel);
                    if (act !== e.exp) begin
                        n_fail++;
                        $display("FAIL %s @%0d: got %h, expected %h", e.name, cyc, act, e.exp);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin : stimulus
        int unsigned t0;
        int unsigned t1;

        // Reset state while rst is held.
        wait_cyc(2);
        push("rst_addr", 3, SelAddr, 20'h0);
        push("rst_hs",   3, SelHs,   20'h1);
        push("rst_vs",   3, SelVs,   20'h1);
        push("rst_ft",   3, SelFt,   20'h0);
        push("rst_rgb",  3, SelRgb,  20'h0);
        wait_cyc(4);
        rst = 1'b0;
        t0 = cyc + 1;  // first negedge after the release edge; scan position p shows at t0+2p

        // First tick latency and colour capture.
        push("first_rgb_hold", t0,     SelRgb,  20'h0);
        push("first_addr",     t0 + 2, SelAddr, 20'h00200);
        push("first_rgb",      t0 + 1, SelRgb,  20'o700);
        push("first_rgb2",     t0 + 2, SelRgb,  20'o700);
        // Horizontal visible edge and hard blanking with rgb_r still 7.
        push("addr_x15",       t0 + 30, SelAddr, 20'h01E00);
        push("addr_x16_blank", t0 + 32, SelAddr, 20'h0);
        push("rgb_blank_x16",  t0 + 34, SelRgb,  20'h0);
        // hs edges: low for output positions h = 18..21.
        push("hs_before", t0 + 36, SelHs, 20'h1);
        push("hs_fall",   t0 + 37, SelHs, 20'h0);
        push("hs_last",   t0 + 44, SelHs, 20'h0);
        push("hs_rise",   t0 + 46, SelHs, 20'h1);
        // Last visible pixel (15,9), then blank, then colour from (15,9).
        push("addr_last_vis",  t0 + 462, SelAddr, 20'h01E09);
        push("addr_after_vis", t0 + 464, SelAddr, 20'h0);
        push("rgb_last_vis",   t0 + 464, SelRgb,  20'o700);
        push("rgb_after_vis",  t0 + 466, SelRgb,  20'h0);
        push("addr_y9",        t0 + 432, SelAddr, 20'h00009);
        // frame_tick exactly when scan becomes (0,10); vs falls 2 lines later.
        push("ft_pre",   t0 + 478, SelFt, 20'h0);
        push("ft_pulse", t0 + 479, SelFt, 20'h1);
        push("ft_post",  t0 + 480, SelFt, 20'h0);
        push("addr_y10", t0 + 480, SelAddr, 20'h0);
        push("vs_before", t0 + 576, SelVs, 20'h1);
        push("vs_fall",   t0 + 577, SelVs, 20'h0);
        // Frame wrap (23,16) -> (0,0) -> (1,0).
        push("addr_corner", t0 + 814, SelAddr, 20'h0);
        push("ft_at_wrap",  t0 + 815, SelFt,   20'h0);
        push("vs_at_wrap",  t0 + 816, SelVs,   20'h1);
        push("addr_wrap",   t0 + 816, SelAddr, 20'h0);
        push("addr_wrap1",  t0 + 818, SelAddr, 20'h00200);
        // One frame of counts, positions 0..407 each seen on two clocks.
        win_lo = t0 + 1;
        win_hi = t0 + 2 * FP;
        push("cnt_hs_low", win_hi, SelHsCnt, 20'(2 * HS * VT));
        push("cnt_vs_low", win_hi, SelVsCnt, 20'(2 * VS * HT));
        push("cnt_r7",     win_hi, SelR7Cnt, 20'(2 * HV * VV));
        push("cnt_nz",     win_hi, SelNzCnt, 20'(2 * HV * VV));
        push("cnt_ft",     win_hi, SelFtCnt, 20'd1);

        // Second frame: pattern colour.
        wait_cyc(t0 + 2 * FP);
        pat_mode = 1'b1;
        push("pat_13_6",  t0 + 1132, SelRgb,  20'o565);
        push("pat_15_9",  t0 + 1280, SelRgb,  20'o717);
        push("addr2_15_9", t0 + 1278, SelAddr, 20'h01E09);
        push("hs_pre_rst", t0 + 1816, SelHs,  20'h0);

        // Third frame: 1-clk reset in the middle of hsync at (20,3).
        wait_cyc(t0 + 1816);
        rst = 1'b1;
        push("mid_rst_hs",   t0 + 1817, SelHs,   20'h1);
        push("mid_rst_vs",   t0 + 1817, SelVs,   20'h1);
        push("mid_rst_rgb",  t0 + 1817, SelRgb,  20'h0);
        push("mid_rst_addr", t0 + 1817, SelAddr, 20'h0);
        push("mid_rst_ft",   t0 + 1817, SelFt,   20'h0);
        wait_cyc(t0 + 1817);
        rst = 1'b0;
        t1 = cyc + 1;
        push("resume_addr",  t1 + 2,   SelAddr, 20'h00200);
        push("resume_rgb",   t1 + 4,   SelRgb,  20'o104);
        push("resume_hs_hi", t1 + 36,  SelHs,   20'h1);
        push("resume_hs_lo", t1 + 37,  SelHs,   20'h0);
        push("resume_addr11", t1 + 50, SelAddr, 20'h00201);
        push("resume_ft0",   t1 + 478, SelFt,   20'h0);
        push("resume_ft",    t1 + 479, SelFt,   20'h1);

        wait_cyc(t1 + 500);
        @(negedge clk);
        while (sb.size() > 0) begin
            chk_t e;
            e = sb.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s: never sampled (due %0d, now %0d)", e.name, e.at, cyc);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_scan_ctrl.md
VGA_SCAN_CTRL -- requirements
Module: vga_scan_ctrl

Interface
REQ-001 Parameter H_VIS, 640, visible pixels per line.
REQ-002 Parameter H_FP, 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, 96, horizontal sync width in pixels.
REQ-004 Parameter H_BP, 48, horizontal back porch in pixels; H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP = 800.
REQ-005 Parameter V_VIS, 480; V_FP, 10; V_SYNC, 2; V_BP, 33, vertical counterparts in lines; V_TOTAL = 525.
REQ-006 clk  in  1  system clock, 50 MHz; the only clock.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 addr  out  20  pixel address to the colour stage: [19]=0, [18:9]=x, [8:0]=y.
REQ-009 rgb_r, rgb_g, rgb_b  in  3 each  colour returned by the colour stage for addr, combinational from addr.
REQ-010 vga_r, vga_g, vga_b  out  3 each  registered pixel colour to the DAC.
REQ-011 vga_hs, vga_vs  out  1 each  registered syncs, active-low.
REQ-012 frame_tick  out  1  one-clk pulse at start of vertical blanking, for sprite-position writes.

Function
REQ-013 pix_en SHALL toggle every clk (25 MHz pixel rate); all counter and output register updates occur only on clk edges where pix_en=1.
REQ-014 h_cnt (10 bit) SHALL increment per pixel tick and wrap from H_TOTAL-1 to 0.
REQ-015 v_cnt (10 bit) SHALL increment on the pixel tick where h_cnt wraps, and wrap from V_TOTAL-1 to 0 on that same tick.
REQ-016 visible = (h_cnt < H_VIS) && (v_cnt < V_VIS), decoded from the current counter registers.
REQ-017 addr SHALL equal {1'b0, h_cnt[9:0], v_cnt[8:0]} when visible, else 20'h0; addr changes only on pixel ticks.
REQ-018 Latency: on each pixel tick the output registers SHALL capture the state of the counters before that tick, so vga_* lag addr by exactly one pixel period (2 clk).
REQ-019 vga_r/g/b SHALL load rgb_* when visible, else 3'b000 (hard blank regardless of rgb_*).
REQ-020 vga_hs SHALL load 0 when H_VIS+H_FP <= h_cnt < H_VIS+H_FP+H_SYNC (656..751), else 1.
REQ-021 vga_vs SHALL load 0 when V_VIS+V_FP <= v_cnt < V_VIS+V_FP+V_SYNC (490..491), else 1.
REQ-022 frame_tick SHALL be 1 for exactly one clk: the clk on which the pixel tick advances counters to h_cnt=0, v_cnt=V_VIS; 0 at all other times; once per frame.
REQ-023 Counter comparisons SHALL be unsigned at 10-bit width; no counter value >= H_TOTAL or >= V_TOTAL is ever reachable.
REQ-024 Simultaneous h and v wrap (799,524 -> 0,0) SHALL complete in one pixel tick with no extra line or frame.
REQ-025 The block SHALL have no handshake with the colour stage; rgb_* is trusted valid one clk after addr changes (the colour stage is combinational).

Reset
REQ-026 While rst=1 on a clk edge: pix_en=0, h_cnt=0, v_cnt=0, vga_r/g/b=0, vga_hs=1, vga_vs=1, frame_tick=0.
REQ-027 First pixel tick after rst deasserts SHALL be the second clk edge (pix_en toggles 0->1 first); addr=20'h0 throughout reset.
REQ-028 rst asserted mid-frame SHALL abort the frame on the next clk edge; the scan restarts at (0,0) with no partial sync pulse stretched beyond reset.

Verification
REQ-029 Release rst, run 2*800*525 clk -> exactly one frame_tick, vga_hs low for 96 pixel ticks per line, vga_vs low for 2 lines (1600 pixel ticks) per frame.
REQ-030 Drive rgb_*=3'b111/000/000 constant -> vga_r=3'b111 only for 640x480 pixel ticks per frame; zero during all blanking even with rgb_r=3'b111.
REQ-031 Counters at (639,479) -> addr=20'h4FFDF; next tick addr=20'h0; one pixel later vga_r holds rgb_r sampled at (639,479).
REQ-032 Counters at (799,524) -> next tick h_cnt=0, v_cnt=0, addr=20'h0, vga_vs=1, no frame_tick.
REQ-033 Assert rst for 1 clk while vga_hs=0 at h_cnt=700 -> next clk vga_hs=1, h_cnt=0, v_cnt=0, outputs zero; scan resumes from (0,0).
REQ-034 Check frame_tick position: pulse coincides with counters becoming (0,480); vga_vs falls 10 lines later.
